// File: rtl/axi_wr_arbiter.sv
// Two-master AXI write arbiter: round-robin AW grant, W/B routed combinationally to the owner, one write in flight.
// Latency: one IDLE cycle to register the grant. Backpressure passes straight through, and non-owner valids stall until granted.
module axi_wr_arbiter #(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int ID_WIDTH   = 4,
  localparam int AWP        = ID_WIDTH + ADDR_WIDTH + 13,
  localparam int WP         = DATA_WIDTH + DATA_WIDTH/8 + 1,
  localparam int BP         = ID_WIDTH + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       m_awvalid,
  input  logic [2*AWP-1:0] m_aw_pl,
  output logic [1:0]       m_awready,
  input  logic [1:0]       m_wvalid,
  input  logic [2*WP-1:0]  m_w_pl,
  output logic [1:0]       m_wready,
  output logic [1:0]       m_bvalid,
  output logic [BP-1:0]    m_b_pl,
  input  logic [1:0]       m_bready,
  output logic             s_awvalid,
  output logic [AWP-1:0]   s_aw_pl,
  input  logic             s_awready,
  output logic             s_wvalid,
  output logic [WP-1:0]    s_w_pl,
  input  logic             s_wready,
  input  logic             s_bvalid,
  input  logic [BP-1:0]    s_b_pl,
  output logic             s_bready,
  output logic [1:0]       grant,
  output logic             wlast_err
);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } aw_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
    logic                    last;
  } w_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       rr_q, rr_d;
  logic [7:0] len_q, len_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  logic g;
  logic win;
  aw_t  aw_sel;
  w_t   w_sel;

  assign g      = grant_q[1];
  assign aw_sel = g ? aw_t'(m_aw_pl[2*AWP-1:AWP]) : aw_t'(m_aw_pl[AWP-1:0]);
  assign w_sel  = g ? w_t'(m_w_pl[2*WP-1:WP])     : w_t'(m_w_pl[WP-1:0]);
  // Both requesting: the preferred master wins; otherwise whoever asks.
  assign win    = (m_awvalid == 2'b11) ? rr_q : m_awvalid[1];

  assign m_b_pl    = s_b_pl;
  assign grant     = grant_q;
  assign wlast_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      rr_q    <= 1'b0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    m_awready = 2'b00;
    m_wready  = 2'b00;
    m_bvalid  = 2'b00;
    s_awvalid = 1'b0;
    s_aw_pl   = '0;
    s_wvalid  = 1'b0;
    s_w_pl    = '0;
    s_bready  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|m_awvalid) begin
          grant_d = win ? 2'b10 : 2'b01;
          state_d = ADDR;
        end
      end

      ADDR: begin
        s_awvalid    = m_awvalid[g];
        s_aw_pl      = aw_sel;
        m_awready[g] = s_awready;
        if (m_awvalid[g] && s_awready) begin
          len_d   = aw_sel.len;
          cnt_d   = 8'd0;
          state_d = DATA;
        end
      end

      DATA: begin
        s_wvalid    = m_wvalid[g];
        s_w_pl      = w_sel;
        m_wready[g] = s_wready;
        if (m_wvalid[g] && s_wready) begin
          cnt_d = cnt_q + 8'd1;
          // Flag wlast disagreeing with the AW length; the beat still goes out.
          err_d = w_sel.last ^ (cnt_q == len_q);
          if (w_sel.last) state_d = RESP;
        end
      end

      RESP: begin
        m_bvalid[g] = s_bvalid;
        s_bready    = m_bready[g];
        if (s_bvalid && m_bready[g]) begin
          rr_d    = ~g;
          grant_d = 2'b00;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: single master, contention, backpressure, length errors, reset mid-burst.
module tb_axi_wr_arbiter;

  localparam int AW_W = 32;
  localparam int DW   = 32;
  localparam int IDW  = 4;
  localparam int AWP  = IDW + AW_W + 13;
  localparam int WP   = DW + DW/8 + 1;
  localparam int BP   = IDW + 2;

  logic             clk;
  logic             rst_n;
  logic [1:0]       m_awvalid;
  logic [2*AWP-1:0] m_aw_pl;
  logic [1:0]       m_awready;
  logic [1:0]       m_wvalid;
  logic [2*WP-1:0]  m_w_pl;
  logic [1:0]       m_wready;
  logic [1:0]       m_bvalid;
  logic [BP-1:0]    m_b_pl;
  logic [1:0]       m_bready;
  logic             s_awvalid;
  logic [AWP-1:0]   s_aw_pl;
  logic             s_awready;
  logic             s_wvalid;
  logic [WP-1:0]    s_w_pl;
  logic             s_wready;
  logic             s_bvalid;
  logic [BP-1:0]    s_b_pl;
  logic             s_bready;
  logic [1:0]       grant;
  logic             wlast_err;

  int checks = 0;
  int errors = 0;

  axi_wr_arbiter #(.ADDR_WIDTH(AW_W), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_awvalid(m_awvalid), .m_aw_pl(m_aw_pl), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_w_pl(m_w_pl), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_b_pl(m_b_pl), .m_bready(m_bready),
    .s_awvalid(s_awvalid), .s_aw_pl(s_aw_pl), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_w_pl(s_w_pl), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_b_pl(s_b_pl), .s_bready(s_bready),
    .grant(grant), .wlast_err(wlast_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AWP-1:0] mk_aw(input int m, input logic [7:0] len);
    logic [IDW-1:0]  id;
    logic [AW_W-1:0] a;
    id = IDW'(m + 3);
    a  = AW_W'(32'h1000 * (m + 1)) + AW_W'(len);
    return {id, a, len, 3'd2, 2'd1};
  endfunction

  function automatic logic [WP-1:0] mk_w(input int m, input int b, input logic last);
    logic [DW-1:0] d;
    d = 32'hD000_0000 | DW'(m << 8) | DW'(b);
    return {d, {(DW/8){1'b1}}, last};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_awvalid"}, s_awvalid, 0);
    chk({tag, "_s_wvalid"},  s_wvalid, 0);
    chk({tag, "_s_bready"},  s_bready, 0);
    chk({tag, "_m_awready"}, m_awready, 0);
    chk({tag, "_m_wready"},  m_wready, 0);
    chk({tag, "_m_bvalid"},  m_bvalid, 0);
    chk({tag, "_grant"},     grant, 0);
    chk({tag, "_wlast_err"}, wlast_err, 0);
  endtask

  // One full write from master m; nb beats, the last carrying wlast.
  task automatic run_write(input int m, input logic [7:0] len, input int nb,
                           input int aw_stall, input bit tog);
    int o;
    int b;
    bit rdy_ph;
    bit err_pend;
    logic last;
    logic [AWP-1:0] aw;
    logic [WP-1:0]  w;
    logic [BP-1:0]  bp;
    o  = 1 - m;
    aw = mk_aw(m, len);
    m_awvalid[m] = 1'b1;
    m_aw_pl[m*AWP +: AWP] = aw;
    m_wvalid[m] = 1'b1;
    m_w_pl[m*WP +: WP] = mk_w(m, 0, nb == 1);
    #1;
    chk("idle_grant", grant, 0);
    chk("idle_s_awvalid", s_awvalid, 0);
    chk("idle_m_wready", m_wready, 0);
    tick();
    chk("addr_grant", grant, 2'b01 << m);
    for (int i = 0; i < aw_stall; i++) begin
      chk("aw_stall_vld", s_awvalid, 1);
      chk("aw_stall_rdy", m_awready, 0);
      chk("w_early_stall", m_wready, 0);
      tick();
    end
    s_awready = 1'b1;
    #1;
    chk("aw_pl", s_aw_pl, aw);
    chk("aw_rdy", m_awready, 2'b01 << m);
    chk("aw_no_w", s_wvalid, 0);
    tick();
    s_awready = 1'b0;
    m_awvalid[m] = 1'b0;
    b = 0;
    err_pend = 1'b0;
    rdy_ph = !tog;
    for (int c = 0; c < 64 && b < nb; c++) begin
      last = (b == nb - 1);
      w = mk_w(m, b, last);
      m_w_pl[m*WP +: WP] = w;
      m_wvalid[m] = 1'b1;
      s_wready = rdy_ph;
      #1;
      chk("w_err", wlast_err, err_pend);
      chk("o_wready", m_wready[o], 0);
      chk("o_awready", m_awready[o], 0);
      chk("s_wvalid", s_wvalid, 1);
      chk("w_pl", s_w_pl, w);
      if (rdy_ph) begin
        chk("w_rdy", m_wready[m], 1);
        err_pend = last ^ (8'(b) == len);
        b++;
      end else begin
        chk("w_hold", m_wready[m], 0);
        err_pend = 1'b0;
      end
      tick();
      if (tog) rdy_ph = !rdy_ph;
    end
    chk("w_beats", b, nb);
    m_wvalid[m] = 1'b0;
    s_wready = 1'b0;
    bp = {IDW'(m + 5), 2'b01};
    s_b_pl = bp;
    #1;
    chk("resp_err", wlast_err, err_pend);
    chk("resp_no_w", s_wvalid, 0);
    chk("resp_grant", grant, 2'b01 << m);
    s_bvalid = 1'b1;
    m_bready[m] = 1'b1;
    #1;
    chk("b_vld", m_bvalid, 2'b01 << m);
    chk("o_bvalid", m_bvalid[o], 0);
    chk("b_rdy", s_bready, 1);
    chk("b_pl", m_b_pl, bp);
    tick();
    s_bvalid = 1'b0;
    m_bready[m] = 1'b0;
    #1;
    chk("post_grant", grant, 0);
    chk("post_bvalid", m_bvalid, 0);
    chk("post_err", wlast_err, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    m_awvalid = '0; m_aw_pl = '0; m_wvalid = '0; m_w_pl = '0; m_bready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_b_pl = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick();

    // Contention straight after reset: m0, m1, then m0 again.
    m_awvalid[1] = 1'b1;
    m_aw_pl[AWP +: AWP] = mk_aw(1, 8'd1);
    run_write(0, 8'd1, 2, 0, 1'b0);
    run_write(1, 8'd1, 2, 0, 1'b0);
    m_awvalid[1] = 1'b1;
    run_write(0, 8'd0, 1, 0, 1'b0);
    run_write(1, 8'd0, 1, 0, 1'b0);

    // Backpressure with m1 pending on AW and W the whole time.
    m_awvalid[1] = 1'b1;
    m_aw_pl[AWP +: AWP] = mk_aw(1, 8'd2);
    m_wvalid[1] = 1'b1;
    m_w_pl[WP +: WP] = mk_w(1, 0, 1'b0);
    run_write(0, 8'd3, 4, 5, 1'b1);
    run_write(1, 8'd2, 3, 0, 1'b0);

    // Single master, awlen=3.
    run_write(0, 8'd3, 4, 0, 1'b0);

    // Length errors: early wlast, then missing wlast.
    run_write(0, 8'd1, 1, 0, 1'b0);
    run_write(0, 8'd0, 2, 0, 1'b0);

    // Reset during beat 2 of an 8-beat burst from m0.
    m_awvalid[0] = 1'b1;
    m_aw_pl[0 +: AWP] = mk_aw(0, 8'd7);
    tick();
    s_awready = 1'b1;
    tick();
    s_awready = 1'b0;
    m_awvalid[0] = 1'b0;
    s_wready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      m_wvalid[0] = 1'b1;
      m_w_pl[0 +: WP] = mk_w(0, b, 1'b0);
      tick();
    end
    m_w_pl[0 +: WP] = mk_w(0, 2, 1'b0);
    #1;
    chk("rst_pre_wvalid", s_wvalid, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    tick();
    chk_all_zero("rst_hold");
    m_wvalid = '0;
    s_wready = 1'b0;
    rst_n = 1'b1;
    tick();
    // Master 0 must be preferred again after reset.
    m_awvalid[1] = 1'b1;
    m_aw_pl[AWP +: AWP] = mk_aw(1, 8'd2);
    run_write(0, 8'd0, 1, 0, 1'b0);
    run_write(1, 8'd2, 3, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
